// File: rtl/cpu_pkg.sv
// Shared types and widths for the fetch front end of the single-issue MIPS core.
package cpu_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned J_INDEX_W = 26;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        ISSUE
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/response channel between the PC sequencer and imem.
interface pc_sequencer_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/next_pc_sel.sv
// Next-PC target arithmetic for the issued instruction: jump > branch > pc+4.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0]  pc4,
    input  logic [INSTR_W-1:0] instr,
    input  logic [ADDR_W-1:0]  branch_offset,
    input  logic               jump,
    input  logic               branch_taken,
    output logic [ADDR_W-1:0]  next_pc
);

    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;
    logic              unused_opcode;

    // J-type keeps the upper nibble of pc+4; the word index fills the rest.
    assign jump_target   = {pc4[ADDR_W-1:J_INDEX_W+2], instr[J_INDEX_W-1:0], 2'b00};
    assign branch_target = pc4 + (branch_offset << 2);
    assign unused_opcode = ^instr[INSTR_W-1:J_INDEX_W];

    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetches one word at a time from imem and holds it for decode.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                jump,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_offset,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   flush_pc,
    pc_sequencer_if.master      imem,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [ADDR_W-1:0]   pc4_out
);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               squash_q, squash_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc4_q, pc4_d;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  flush_target;

    assign flush_target = flush_pc & ~ADDR_W'(3);

    next_pc_sel u_next_pc_sel (
        .pc4           (pc4_q),
        .instr         (instr_q),
        .branch_offset (branch_offset),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .next_pc       (next_pc)
    );

    // Next-state and next-output logic; flush takes precedence over everything else.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        req_d    = req_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
                if (flush) begin
                    pc_d   = flush_target;
                    addr_d = flush_target;
                end
            end

            FETCH: begin
                if (flush) begin
                    pc_d = flush_target;
                    // An in-flight request cannot be withdrawn; its data is discarded on arrival.
                    if (imem.imem_ready) begin
                        addr_d   = flush_target;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (imem.imem_ready) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        addr_d   = pc_q;
                    end else begin
                        instr_d = imem.imem_rdata;
                        pc4_d   = pc_q + ADDR_W'(4);
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if (flush) begin
                    pc_d    = flush_target;
                    addr_d  = flush_target;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!stall) begin
                    pc_d    = next_pc;
                    addr_d  = next_pc;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = BOOT;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VECTOR;
            squash_q <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= RESET_VECTOR;
            valid_q  <= 1'b0;
            instr_q  <= NOP_WORD;
            pc4_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instr_valid    = valid_q;
    assign instr_out      = instr_q;
    assign pc4_out        = pc4_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: random fetch/redirect traffic against a transaction-level model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;

    pc_sequencer_if mif ();

    pc_sequencer #(.RESET_VECTOR(RV)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .imem          (mif),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .pc4_out       (pc4_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_fetch_q[$];
    logic [63:0] exp_issue_q[$];
    logic [31:0] mem_ovr[logic [31:0]];

    // Model state: address being fetched, pending redirect after a squashed fetch, issued word.
    logic [31:0] m_fa;
    logic        m_sq;
    logic [31:0] m_redir;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;

    // Next-cycle stimulus; tick() applies it and restores the defaults.
    logic        d_ready, d_stall, d_jump, d_branch, d_flush, d_rst, d_late;
    logic [31:0] d_off, d_fpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %h, nothing expected (t=%0t)", name, act, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        if (a[6:2] == 5'd3) return 32'h0000_0000;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] pc4, input logic [31:0] instr,
                                                 input logic [31:0] off, input logic j, input logic b);
        if (j) return (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
        if (b) return pc4 + off * 32'd4;
        return pc4;
    endfunction

    task automatic clear_drive();
        d_ready = 1'b0; d_stall = 1'b0; d_jump = 1'b0; d_branch = 1'b0;
        d_flush = 1'b0; d_rst = 1'b0; d_late = 1'b0; d_off = 32'h0; d_fpc = 32'h0;
    endtask

    // Drive one cycle of inputs, advance the model by the same cycle, then move to the next cycle.
    task automatic tick();
        logic req_now, val_now, done;
        req_now = mif.imem_req;
        val_now = instr_valid;
        done    = d_ready && req_now && !d_rst;

        reset          = d_rst;
        stall          = d_stall;
        jump           = d_jump;
        branch_taken   = d_branch;
        branch_offset  = d_off;
        flush          = d_flush;
        flush_pc       = d_fpc;
        mif.imem_ready = d_late || done;
        mif.imem_rdata = done ? mem_word(mif.imem_addr) : $urandom;

        if (d_rst) begin
            m_fa = RV;
            m_sq = 1'b0;
        end else if (req_now) begin
            if (done) begin
                exp_fetch_q.push_back(m_fa);
                if (d_flush) begin
                    m_fa = d_fpc & ~32'd3;
                    m_sq = 1'b0;
                end else if (m_sq) begin
                    m_fa = m_redir;
                    m_sq = 1'b0;
                end else begin
                    m_instr = mem_word(m_fa);
                    m_pc4   = m_fa + 32'd4;
                    exp_issue_q.push_back({m_instr, m_pc4});
                end
            end else if (d_flush) begin
                m_sq    = 1'b1;
                m_redir = d_fpc & ~32'd3;
            end
        end else if (val_now) begin
            if (d_flush) m_fa = d_fpc & ~32'd3;
            else if (!d_stall) m_fa = model_target(m_pc4, m_instr, d_off, d_jump, d_branch);
        end else if (d_flush) begin
            m_fa = d_fpc & ~32'd3;
        end

        clear_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_issue();
        for (int n = 0; n < 40 && !instr_valid; n++) begin
            d_ready = 1'b1;
            tick();
        end
        check("issue_reached", 32'(instr_valid), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] a);
        run_to_issue();
        d_flush = 1'b1;
        d_fpc   = a;
        tick();
    endtask

    // Monitor: completed fetches and issued instructions are checked against the queues.
    logic        prev_valid = 1'b0;
    logic [63:0] cur_issue  = 64'h0;

    always @(negedge clk) begin
        if (mif.imem_req && mif.imem_ready) begin
            if (exp_fetch_q.size() == 0) fail("unexpected_fetch", mif.imem_addr);
            else check("fetch_addr", mif.imem_addr, exp_fetch_q.pop_front());
        end
        if (instr_valid) begin
            if (!prev_valid) begin
                if (exp_issue_q.size() == 0) begin
                    fail("unexpected_issue", instr_out);
                    cur_issue = {instr_out, pc4_out};
                end else begin
                    cur_issue = exp_issue_q.pop_front();
                end
            end
            check("instr_out", instr_out, cur_issue[63:32]);
            check("pc4_out", pc4_out, cur_issue[31:0]);
            check("no_req_in_issue", 32'(mif.imem_req), 32'd0);
        end
        prev_valid = instr_valid;
    end

    localparam logic [6:0] REQ_PAT   = 7'b0101010;
    localparam logic [6:0] VALID_PAT = 7'b1010100;

    initial begin
        logic [6:0] req_pat, valid_pat;
        req_pat   = REQ_PAT;
        valid_pat = VALID_PAT;
        mem_ovr[32'h0040_0000] = 32'h0800_0010;
        mem_ovr[32'h0000_0100] = 32'h0000_0123;
        m_fa = RV; m_sq = 1'b0; m_redir = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        clear_drive();

        d_rst = 1'b1; tick();
        d_rst = 1'b1; tick();
        check("reset_req", 32'(mif.imem_req), 32'd0);
        check("reset_valid", 32'(instr_valid), 32'd0);
        check("reset_instr", instr_out, 32'h0);
        check("reset_pc4", pc4_out, 32'h0);

        // Zero-wait memory: one instruction every other cycle from the reset vector.
        for (int k = 0; k < 7; k++) begin
            check("seq_req", 32'(mif.imem_req), 32'(req_pat[k]));
            check("seq_valid", 32'(instr_valid), 32'(valid_pat[k]));
            d_ready = 1'b1;
            tick();
        end

        redirect(32'h0040_0000);
        run_to_issue();
        d_jump = 1'b1;
        tick();
        check("jump_addr", mif.imem_addr, 32'h0000_0040);
        check("jump_req", 32'(mif.imem_req), 32'd1);

        redirect(32'h0000_0100);
        run_to_issue();
        d_branch = 1'b1; d_off = 32'hFFFF_FFFE;
        tick();
        check("branch_addr", mif.imem_addr, 32'h0000_00FC);

        redirect(32'h0000_0100);
        run_to_issue();
        d_jump = 1'b1; d_branch = 1'b1; d_off = 32'hFFFF_FFFE;
        tick();
        check("jump_over_branch", mif.imem_addr, 32'h0000_048C);

        run_to_issue();
        for (int k = 0; k < 3; k++) begin
            d_stall = 1'b1; d_jump = 1'b1; d_branch = 1'b1; d_off = 32'h10;
            tick();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_req", 32'(mif.imem_req), 32'd0);
            check("stall_pc4", pc4_out, 32'h0000_0490);
            check("stall_instr", instr_out, mem_word(32'h0000_048C));
        end
        tick();
        check("unstall_req", 32'(mif.imem_req), 32'd1);
        check("unstall_addr", mif.imem_addr, 32'h0000_0490);

        // Flush while the fetch at 0x20 is outstanding: address held, its word discarded.
        redirect(32'h0000_0020);
        d_flush = 1'b1; d_fpc = 32'h0000_0082;
        tick();
        for (int k = 0; k < 2; k++) begin
            check("squash_hold_addr", mif.imem_addr, 32'h0000_0020);
            check("squash_hold_req", 32'(mif.imem_req), 32'd1);
            tick();
        end
        d_ready = 1'b1;
        tick();
        check("squash_valid", 32'(instr_valid), 32'd0);
        check("squash_next_addr", mif.imem_addr, 32'h0000_0080);
        check("squash_next_req", 32'(mif.imem_req), 32'd1);
        run_to_issue();

        redirect(32'h0000_0020);
        d_ready = 1'b1; d_flush = 1'b1; d_fpc = 32'h0000_0080;
        tick();
        check("coinc_valid", 32'(instr_valid), 32'd0);
        check("coinc_addr", mif.imem_addr, 32'h0000_0080);
        check("coinc_req", 32'(mif.imem_req), 32'd1);
        run_to_issue();

        // Reset during a fetch wait; a late ready in the boot cycle must be ignored.
        redirect(32'h0000_0020);
        tick();
        d_rst = 1'b1;
        tick();
        check("rst_mid_req", 32'(mif.imem_req), 32'd0);
        check("rst_mid_valid", 32'(instr_valid), 32'd0);
        d_late = 1'b1;
        tick();
        check("restart_req", 32'(mif.imem_req), 32'd1);
        check("restart_addr", mif.imem_addr, RV);
        run_to_issue();

        for (int i = 0; i < 3000; i++) begin
            d_ready  = ($urandom_range(0, 99) < 60);
            d_stall  = ($urandom_range(0, 99) < 30);
            d_jump   = ($urandom_range(0, 99) < 15);
            d_branch = ($urandom_range(0, 99) < 25);
            d_off    = 32'($urandom_range(0, 63)) - 32'd32;
            if ((mif.imem_req || instr_valid) && $urandom_range(0, 99) < 4) begin
                d_flush = 1'b1;
                d_fpc   = $urandom;
            end
            if ($urandom_range(0, 999) < 3) d_rst = 1'b1;
            tick();
        end

        run_to_issue();
        @(negedge clk);
        #1;
        check("fetch_q_drained", 32'(exp_fetch_q.size()), 32'd0);
        check("issue_q_drained", 32'(exp_issue_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
